deserializador8: RTL and testbench



---
 rtl/deserializador8_pkg.sv | 17 +
 rtl/deserializador8_registro_desplazamiento.sv | 31 +++
 rtl/deserializador8.sv | 108 ++++++++++
 tb/tb_deserializador8.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/deserializador8_pkg.sv
// Shared types and constants for the serial-to-parallel capture stage.
package deserializador8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N_BITS = 8;

    // Bit-counter width; kept at least 1 so degenerate frame lengths still elaborate.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deserializador8_registro_desplazamiento.sv
// N-bit shift register with synchronous clear and shift-enable; direction chosen by LSB_FIRST.
module registro_desplazamiento
    import deserializador8_pkg::*;
#(
    parameter int unsigned N         = DEFAULT_N_BITS,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [N-1:0] q
);

    // Clear wins over shift so a restart never mixes in a stale bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            if (LSB_FIRST) begin
                q <= {din, q[N-1:1]};
            end else begin
                q <= {q[N-2:0], din};
            end
        end
    end

endmodule

// File: rtl/deserializador8.sv
// Collects an N_BITS frame from a serial input under start/bit_valid handshake and
// strobes load for one cycle when complete; data feeds a downstream enable-loaded register.
module deserializador8
    import deserializador8_pkg::*;
#(
    parameter int unsigned N_BITS    = DEFAULT_N_BITS,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din,
    input  logic              bit_valid,
    input  logic              cancel,
    output logic [N_BITS-1:0] data,
    output logic              load,
    output logic              busy
);

    localparam int unsigned      CNT_W = cnt_width(N_BITS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_BITS - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             sr_clr;
    logic             sr_shift;
    logic             load_nx;
    logic             busy_nx;

    // State register, bit counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            load  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            load  <= load_nx;
            busy  <= busy_nx;
        end
    end

    // Next-state logic; cancel outranks bit_valid while shifting.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (bit_valid && (cnt == LAST)) begin
                    state_nx = LOAD;
                end
            end
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath controls and next values of the registered outputs.
    always_comb begin
        sr_clr   = 1'b0;
        sr_shift = 1'b0;
        cnt_nx   = cnt;
        load_nx  = (state_nx == LOAD);
        busy_nx  = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    sr_clr = 1'b1;
                    cnt_nx = '0;
                end
            end
            SHIFT: begin
                if (cancel) begin
                    sr_clr = 1'b1;
                    cnt_nx = '0;
                end else if (bit_valid) begin
                    sr_shift = 1'b1;
                    cnt_nx   = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    registro_desplazamiento #(
        .N         (N_BITS),
        .LSB_FIRST (LSB_FIRST)
    ) u_sr (
        .clk      (clk),
        .rst      (rst),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .din      (din),
        .q        (data)
    );

endmodule

// File: tb/tb_deserializador8.sv
// Scoreboard bench: one LSB-first and one MSB-first instance, directed frames.
module tb_deserializador8;

    logic       clk;
    logic       rst;
    logic       din;
    logic       cancel;
    logic       start0, bv0, start1, bv1;
    logic [7:0] data0, data1;
    logic       load0, busy0, load1, busy1;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       prev_load0 = 1'b0;
    logic       prev_load1 = 1'b0;
    int         last_load0 = -1;
    int         prev_load0_t = -1;
    logic [7:0] dq0;

    deserializador8 #(.N_BITS(8), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .din(din), .bit_valid(bv0),
        .cancel(cancel), .data(data0), .load(load0), .busy(busy0)
    );

    deserializador8 #(.N_BITS(8), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .din(din), .bit_valid(bv1),
        .cancel(cancel), .data(data1), .load(load1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream enable-loaded register fed by dut0.
    always @(posedge clk or posedge rst) begin
        if (rst) dq0 <= 8'h00;
        else if (load0) dq0 <= data0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every load pulse must match the next queued frame and be one cycle wide.
    always @(negedge clk) begin
        if (load0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load0_unexpected actual=%0h required=none", data0);
            end else begin
                chk("load0_data", 32'(data0), 32'(q0.pop_front()));
            end
            chk("load0_width", 32'(prev_load0), 32'd0);
            prev_load0_t = last_load0;
            last_load0   = cyc;
        end
        if (load1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load1_unexpected actual=%0h required=none", data1);
            end else begin
                chk("load1_data", 32'(data1), 32'(q1.pop_front()));
            end
            chk("load1_width", 32'(prev_load1), 32'd0);
        end
        prev_load0 = load0;
        prev_load1 = load1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full LSB-first frame on dut0; optional spurious starts during SHIFT and LOAD.
    task automatic frame0(input logic [7:0] val, input bit noise_start);
        q0.push_back(val);
        start0 = 1'b1;
        bv0    = 1'b1;
        din    = ~val[0];
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din    = val[i];
            bv0    = 1'b1;
            start0 = noise_start && (i == 3);
            tick();
        end
        bv0    = 1'b0;
        din    = 1'b0;
        start0 = noise_start;
        @(negedge clk);
        chk("frame_load_high", 32'(load0), 32'd1);
        chk("frame_busy_load", 32'(busy0), 32'd1);
        tick();
        start0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; cancel = 1'b0;
        start0 = 1'b0; bv0 = 1'b0; start1 = 1'b0; bv1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", 32'(data0), 32'h00);
        chk("rst_load", 32'(load0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        tick();

        // Serial activity without start is ignored.
        for (int i = 0; i < 5; i++) begin
            din = i[0]; bv0 = 1'b1; bv1 = 1'b1;
            tick();
        end
        bv0 = 1'b0; bv1 = 1'b0;
        @(negedge clk);
        chk("idle_data0", 32'(data0), 32'h00);
        chk("idle_busy0", 32'(busy0), 32'd0);
        chk("idle_data1", 32'(data1), 32'h00);
        tick();

        // LSB-first 0xA5.
        frame0(8'hA5, 1'b0);
        @(negedge clk);
        chk("a5_load_low", 32'(load0), 32'd0);
        chk("a5_busy_low", 32'(busy0), 32'd0);
        chk("a5_data_hold", 32'(data0), 32'hA5);
        chk("a5_downstream", 32'(dq0), 32'hA5);
        tick();

        // MSB-first 0x3C with a three-cycle gap after the fourth bit.
        q1.push_back(8'h3C);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'h3C;
            din = v[7-i];
            bv1 = 1'b1;
            tick();
            if (i == 3) begin
                bv1 = 1'b0;
                din = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("gap_load1", 32'(load1), 32'd0);
                    chk("gap_busy1", 32'(busy1), 32'd1);
                    tick();
                end
            end
        end
        bv1 = 1'b0;
        @(negedge clk);
        chk("msb_load_high", 32'(load1), 32'd1);
        tick();
        @(negedge clk);
        chk("msb_load_low", 32'(load1), 32'd0);
        chk("msb_data", 32'(data1), 32'h3C);
        tick();

        // Cancel after five ones, in the same cycle as bit_valid.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; bv0 = 1'b1;
            tick();
        end
        @(negedge clk);
        chk("partial_data", 32'(data0), 32'hF8);
        din = 1'b1; bv0 = 1'b1; cancel = 1'b1;
        tick();
        bv0 = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 32'(busy0), 32'd0);
        chk("cancel_data", 32'(data0), 32'h00);
        chk("cancel_load", 32'(load0), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("cancel_downstream", 32'(dq0), 32'hA5);
        tick();

        // Spurious starts in SHIFT and LOAD, then back-to-back 0xFF.
        frame0(8'h96, 1'b1);
        frame0(8'hFF, 1'b0);
        @(negedge clk);
        chk("b2b_data", 32'(data0), 32'hFF);
        chk("b2b_downstream", 32'(dq0), 32'hFF);
        chk("b2b_gap", 32'(last_load0 - prev_load0_t), 32'd10);
        tick();

        // Asynchronous reset between edges while bit 6 is presented.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; bv0 = 1'b1;
            tick();
        end
        din = 1'b1; bv0 = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_load", 32'(load0), 32'd0);
        chk("arst_data", 32'(data0), 32'h00);
        #1 rst = 1'b0;
        bv0 = 1'b0;
        repeat (2) tick();

        frame0(8'h01, 1'b0);
        @(negedge clk);
        chk("post_rst_data", 32'(data0), 32'h01);
        chk("post_rst_downstream", 32'(dq0), 32'h01);

        repeat (4) tick();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
